// File: rtl/uart_txrx_core.sv
// uart_txrx_core
//   Single-clock UART core: selectable 16x baud-tick generator, 8-bit TX framer
//   and 8-bit RX deframer. Frame = start, 8 data bits LSB-first, even parity, stop.
//   TX start/stop slot levels come from ports so framing faults can be injected.
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   sel[1:0]         baud select, picks DIV0..DIV3 clks per oversample tick
//   start_bit        level driven in the TX start slot (1 suppresses the frame)
//   stop_bit         level driven in the TX stop slot
//   tx_data[7:0]     byte to transmit, captured at frame start
//   tx_out           serial TX line, idles high
//   rx_in            serial RX line (asynchronous)
//   data_out[7:0]    last received byte
//   rx_valid         1-clk pulse per completed RX frame
//   parity_error     parity check result of last frame
//   stopbit_error    stop-bit check result of last frame
module uart_txrx_core #(
    parameter int DIV0 = 326,
    parameter int DIV1 = 163,
    parameter int DIV2 = 81,
    parameter int DIV3 = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       start_bit,
    input  logic       stop_bit,
    input  logic [7:0] tx_data,
    output logic       tx_out,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       stopbit_error
);
    localparam int CW = 16;

    // ---------------- tick generator ----------------
    logic [CW-1:0] div_m1;
    logic [CW-1:0] tick_cnt;
    logic [1:0]    sel_q;
    logic          tick;

    always_comb begin
        case (sel)
            2'b00:   div_m1 = CW'(DIV0 - 1);
            2'b01:   div_m1 = CW'(DIV1 - 1);
            2'b10:   div_m1 = CW'(DIV2 - 1);
            default: div_m1 = CW'(DIV3 - 1);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q    <= 2'b00;
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            sel_q <= sel;
            if (sel != sel_q) begin
                // new rate: restart the period from zero
                tick_cnt <= '0;
                tick     <= 1'b0;
            end else if (tick_cnt >= div_m1) begin
                tick_cnt <= '0;
                tick     <= 1'b1;
            end else begin
                tick_cnt <= tick_cnt + CW'(1);
                tick     <= 1'b0;
            end
        end
    end

    // ---------------- TX framer ----------------
    typedef enum logic [1:0] {TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t  tx_state;
    logic       tx_run;      // low until the first frame after reset is loaded
    logic [3:0] tx_tcnt;     // ticks within the current bit slot
    logic [2:0] tx_idx;
    logic [7:0] tx_shift;
    logic       tx_par;
    logic       tx_start_q;
    logic       tx_stop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state   <= TX_START;
            tx_run     <= 1'b0;
            tx_tcnt    <= 4'd0;
            tx_idx     <= 3'd0;
            tx_shift   <= 8'h00;
            tx_par     <= 1'b0;
            tx_start_q <= 1'b1;
            tx_stop_q  <= 1'b1;
            tx_out     <= 1'b1;
        end else if (tick) begin
            if (!tx_run || (tx_state == TX_STOP && tx_tcnt == 4'd15)) begin
                // frame boundary: capture byte and slot levels for the whole frame
                tx_run     <= 1'b1;
                tx_state   <= TX_START;
                tx_tcnt    <= 4'd0;
                tx_idx     <= 3'd0;
                tx_shift   <= tx_data;
                tx_par     <= ^tx_data;
                tx_start_q <= start_bit;
                tx_stop_q  <= stop_bit;
                tx_out     <= start_bit;
            end else if (tx_tcnt == 4'd15) begin
                tx_tcnt <= 4'd0;
                // a high start slot holds the line high for every slot of the frame
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_out   <= tx_start_q | tx_shift[0];
                    end
                    TX_DATA: begin
                        tx_shift <= tx_shift >> 1;
                        if (tx_idx == 3'd7) begin
                            tx_state <= TX_PARITY;
                            tx_out   <= tx_start_q | tx_par;
                        end else begin
                            tx_idx <= tx_idx + 3'd1;
                            tx_out <= tx_start_q | tx_shift[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state <= TX_STOP;
                        tx_out   <= tx_start_q | tx_stop_q;
                    end
                    default: tx_state <= TX_STOP;
                endcase
            end else begin
                tx_tcnt <= tx_tcnt + 4'd1;
            end
        end
    end

    // ---------------- RX deframer ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    rx_state_t  rx_state;
    logic       rx_s1, rx_s2;
    logic       rx_hold;     // after a bad stop bit, wait for a high line before rearming
    logic [3:0] rx_tcnt;
    logic [2:0] rx_idx;
    logic [7:0] rx_shift;
    logic       rx_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_hold       <= 1'b0;
            rx_tcnt       <= 4'd0;
            rx_idx        <= 3'd0;
            rx_shift      <= 8'h00;
            rx_par        <= 1'b0;
            data_out      <= 8'h00;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            stopbit_error <= 1'b0;
        end else begin
            rx_s1    <= rx_in;
            rx_s2    <= rx_s1;
            rx_valid <= 1'b0;
            if (tick) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (rx_hold) begin
                            if (rx_s2) rx_hold <= 1'b0;
                        end else if (!rx_s2) begin
                            rx_state <= RX_START;
                            rx_tcnt  <= 4'd0;
                        end
                    end
                    RX_START: begin
                        // half a bit in: still low means a real start, else a glitch
                        if (rx_tcnt == 4'd7) begin
                            rx_tcnt  <= 4'd0;
                            rx_idx   <= 3'd0;
                            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_tcnt == 4'd15) begin
                            rx_tcnt  <= 4'd0;
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            if (rx_idx == 3'd7) rx_state <= RX_PARITY;
                            else                rx_idx   <= rx_idx + 3'd1;
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                    RX_PARITY: begin
                        if (rx_tcnt == 4'd15) begin
                            rx_tcnt  <= 4'd0;
                            rx_par   <= rx_s2;
                            rx_state <= RX_STOP;
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                    RX_STOP: begin
                        if (rx_tcnt == 4'd15) begin
                            rx_tcnt       <= 4'd0;
                            data_out      <= rx_shift;
                            parity_error  <= (^rx_shift) != rx_par;
                            stopbit_error <= !rx_s2;
                            rx_hold       <= !rx_s2;
                            rx_valid      <= 1'b1;
                            rx_state      <= RX_IDLE;
                        end else begin
                            rx_tcnt <= rx_tcnt + 4'd1;
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_txrx_core.sv
// tb_uart_txrx_core
//   Loops tx_out back to rx_in (with an optional inversion window) and checks
//   the serial line and received results against a frame-level model.
module tb_uart_txrx_core;
    localparam int F   = 176;       // frame length in clks at sel=11 (11 slots x 16 ticks)
    localparam int BP0 = 16 * 326;  // bit period in clks at sel=00

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'b11;
    logic       start_bit = 1'b1;
    logic       stop_bit = 1'b0;
    logic [7:0] tx_data = 8'h69;
    logic       inv_rx = 1'b0;
    logic       tx_out, rx_in, rx_valid, parity_error, stopbit_error;
    logic [7:0] data_out;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int vcount = 0;
    int t0;

    logic [7:0] exp_data;
    logic       exp_perr, exp_serr;
    logic [7:0] cur_d;
    logic       cur_st, cur_sp;

    assign rx_in = tx_out ^ inv_rx;

    uart_txrx_core dut (
        .clk(clk), .rst(rst), .sel(sel), .start_bit(start_bit), .stop_bit(stop_bit),
        .tx_data(tx_data), .tx_out(tx_out), .rx_in(rx_in), .data_out(data_out),
        .rx_valid(rx_valid), .parity_error(parity_error), .stopbit_error(stopbit_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid === 1'b1) vcount <= vcount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Expected line level per bit slot (index 0 = start slot).
    function automatic logic [10:0] line_bits(input logic [7:0] d, input logic st, input logic sp);
        logic [10:0] b;
        if (st) return 11'h7ff;
        b[0]   = 1'b0;
        b[8:1] = d;
        b[9]   = 1'($countones(d) % 2);
        b[10]  = sp;
        return b;
    endfunction

    // What a receiver should report for a line carrying these slot levels.
    task automatic model_rx(input logic [10:0] b);
        exp_data = b[8:1];
        exp_perr = (($countones(b[8:1]) + int'(b[9])) % 2) != 0;
        exp_serr = !b[10];
    endtask

    task automatic wait_tx_low(input int limit, output int at);
        int n;
        n = 0;
        while (tx_out !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("tx_frame_start_seen", tx_out, 0);
        at = cyc;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_tx_out"}, tx_out, 1);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_parity_error"}, parity_error, 0);
        chk({tag, "_stopbit_error"}, stopbit_error, 0);
    endtask

    // Run frame n (sel=11): check every slot of the line, apply next-frame inputs
    // mid-frame, optionally invert the looped line over the parity slot, then
    // check the receiver's result for this frame.
    task automatic frame(input int n, input logic [7:0] nd, input logic nst, input logic nsp,
                         input logic invp);
        logic [10:0] b, rb;
        int vbase;
        b = line_bits(cur_d, cur_st, cur_sp);
        goto_cyc(t0 + n * F);
        vbase = vcount;
        for (int off = 0; off < F; off++) begin
            goto_cyc(t0 + n * F + off);
            inv_rx = invp && off >= 147 && off <= 158;
            if (off == 100) begin
                tx_data   = nd;
                start_bit = nst;
                stop_bit  = nsp;
            end
            if (off % 16 == 1 || off % 16 == 8 || off % 16 == 15)
                chk($sformatf("f%0d_slot%0d_off%0d", n, off / 16, off), tx_out, b[off / 16]);
            if (off == 174) begin
                rb = b;
                rb[9] = rb[9] ^ invp;
                if (!cur_st) model_rx(rb);
                chk($sformatf("f%0d_rx_pulses", n), vcount - vbase, cur_st ? 0 : 1);
                chk($sformatf("f%0d_data_out", n), data_out, exp_data);
                chk($sformatf("f%0d_parity_error", n), parity_error, exp_perr);
                chk($sformatf("f%0d_stopbit_error", n), stopbit_error, exp_serr);
            end
        end
        cur_d  = nd;
        cur_st = nst;
        cur_sp = nsp;
    endtask

    initial begin
        logic [7:0] rd [6];
        logic       rp [6];
        logic       saw_low;
        logic [10:0] lb;
        int n, vbase, rel;

        foreach (rd[i]) begin
            rd[i] = 8'($urandom_range(0, 255));
            rp[i] = 1'($urandom_range(0, 1));
        end

        // reset values
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");

        // suppressed frames: start slot high keeps the whole line high
        rst = 1'b0;
        saw_low = 1'b0;
        repeat (3 * F) begin
            @(negedge clk);
            if (tx_out !== 1'b1) saw_low = 1'b1;
        end
        chk("quiet_line_low_seen", saw_low, 0);
        chk("quiet_rx_pulses", vcount, 0);

        // normal framing from the next frame boundary
        start_bit = 1'b0;
        stop_bit  = 1'b1;
        wait_tx_low(2 * F, t0);
        cur_d = 8'h69; cur_st = 1'b0; cur_sp = 1'b1;
        exp_data = 8'h00; exp_perr = 1'b0; exp_serr = 1'b0;

        frame(0, 8'h69, 1'b0, 1'b0, 1'b0);   // clean 0x69
        frame(1, 8'h69, 1'b1, 1'b1, 1'b0);   // stop slot low -> stopbit_error
        frame(2, 8'h69, 1'b0, 1'b1, 1'b0);   // quiet frame, flags must hold
        frame(3, 8'h69, 1'b0, 1'b1, 1'b1);   // parity slot inverted on the wire
        frame(4, rd[0], 1'b0, 1'b1, 1'b0);   // clean frame clears parity_error
        for (int i = 0; i < 6; i++)
            frame(5 + i, (i < 5) ? rd[i + 1] : 8'h69, 1'b0, 1'b1, rp[i]);

        // reset in the middle of data bit 3 at sel=11
        goto_cyc(t0 + 11 * F + 72);
        rst = 1'b1;
        #1;
        chk_reset_outs("rst11");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        vbase = vcount;
        wait_tx_low(3 * F, t0);
        chk("rst11_fresh_start", (t0 - rel) <= 8, 1);
        chk("rst11_no_rx", vcount - vbase, 0);
        exp_data = 8'h00; exp_perr = 1'b0; exp_serr = 1'b0;
        frame(0, 8'h69, 1'b0, 1'b1, 1'b0);

        // switch to sel=00 under reset, then reset again mid data bit 3
        rst = 1'b1;
        sel = 2'b00;
        #1;
        chk_reset_outs("rst00a");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_tx_low(2 * 326 + 16, t0);
        goto_cyc(t0 + 4 * BP0 + BP0 / 2);
        lb = line_bits(8'h69, 1'b0, 1'b1);
        chk("sel00_bit3_level", tx_out, lb[4]);
        rst = 1'b1;
        #1;
        chk_reset_outs("rst00b");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vbase = vcount;
        wait_tx_low(2 * 326 + 16, t0);

        // start slot width = one bit period (bit0 of 0x69 is high)
        n = 0;
        while (tx_out === 1'b0 && n < BP0 + 100) begin
            @(negedge clk);
            n++;
        end
        chk("sel00_bit_period", n, BP0);

        n = 0;
        while (vcount == vbase && n < 12 * BP0) begin
            @(negedge clk);
            n++;
        end
        chk("sel00_rx_pulses", vcount - vbase, 1);
        chk("sel00_data_out", data_out, 8'h69);
        chk("sel00_parity_error", parity_error, 0);
        chk("sel00_stopbit_error", stopbit_error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
